uartrx_ctrl: RTL

- Sequencing controller for the UART receiver.
- Drives the receiver's go/data_ready handshake autonomously: arms the receiver, captures each completed byte, acknowledges it, and re-arms.
- Buffers received bytes in a show-ahead FIFO so the CPU-side I/O logic can read them at its own pace.
- Sits between the UART receiver instance and the memory-mapped I/O read path.

---
 rtl/uartrx_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/uartrx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uartrx_ctrl
// Description : Sequencing controller for the UART receiver. Arms the
//               receiver, captures each completed byte into a show-ahead
//               FIFO, acknowledges it and re-arms when there is room.
// Revision    : 1.0 - initial release
// ============================================================================
module uartrx_ctrl #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     flush,
  output logic                     urx_go,
  input  logic [7:0]               urx_data,
  input  logic                     urx_data_ready,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic [c_cw-1:0] c_depth   = c_cw'(DEPTH);
  localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);
  localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              go_q, go_d;
  logic [c_aw-1:0]   wr_ptr_q, wr_ptr_d;
  logic [c_aw-1:0]   rd_ptr_q, rd_ptr_d;
  logic [c_cw-1:0]   count_q, count_d;
  logic [7:0]        mem_q [DEPTH];
  logic              w_push;
  logic              w_pop;

  assign urx_go   = go_q;
  assign count    = count_q;
  assign rd_valid = (count_q != '0);
  assign full     = (count_q == c_depth);
  assign rd_data  = mem_q[rd_ptr_q];
  assign w_pop    = rd_en && rd_valid;

  // Handshake FSM: arm only with room and a quiet data_ready, capture, wait for ack release.
  always_comb begin
    state_d = state_q;
    go_d    = 1'b0;
    w_push  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && !full && !urx_data_ready) begin
          state_d = S_ARMED;
          go_d    = 1'b1;
        end
      end
      S_ARMED: begin
        if (urx_data_ready) begin
          state_d = S_ACK;
          w_push  = 1'b1;
        end else if (!enable) begin
          state_d = S_IDLE;
        end else begin
          go_d = 1'b1;
        end
      end
      S_ACK: begin
        if (!urx_data_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointer and occupancy update; flush overrides any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + c_ptr_one;
      if (w_pop)  rd_ptr_d = rd_ptr_q + c_ptr_one;
      if (w_push && !w_pop)      count_d = count_q + c_cnt_one;
      else if (w_pop && !w_push) count_d = count_q - c_cnt_one;
    end
  end

  // State, go and FIFO control registers; reset drops go immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      go_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      go_q     <= go_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Byte storage; a byte captured in a flush cycle is simply not written.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      mem_q[wr_ptr_q] <= urx_data;
    end
  end

endmodule
`default_nettype wire
